// File: rtl/frame_capture_sink_if.sv
// Pixel stream handshake between a filter stage (master) and the frame capture sink (slave).
interface frame_capture_sink_if #(
  parameter int unsigned PIX_W = 8
);
  logic             s_valid;
  logic             s_ready;
  logic [PIX_W-1:0] s_data;
  logic             s_sof;
  logic             s_eol;

  modport master (output s_valid, output s_data, output s_sof, output s_eol, input s_ready);
  modport slave  (input s_valid, input s_data, input s_sof, input s_eol, output s_ready);
endinterface

// File: rtl/frame_capture_sink.sv
// Captures one raster-order grayscale frame into internal RAM with geometry checking and a read port.
// Optional running pixel checksum enabled by defining CAPTURE_CHECKSUM_EN.
module frame_capture_sink #(
  parameter int unsigned ROWS   = 168,
  parameter int unsigned COLS   = 220,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned ADDR_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  frame_capture_sink_if.slave  s,
  input  logic                 frame_ack,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [PIX_W-1:0]     rd_data,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 err_geom,
  output logic [15:0]          checksum
);

  localparam int unsigned DEPTH = ROWS * COLS;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t            state;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic [IDX_W-1:0]  wr_addr;
  logic [PIX_W-1:0]  mem [DEPTH];

  logic              beat_c;
  logic              we_c;
  logic [ROW_W-1:0]  beat_row_c;
  logic [COL_W-1:0]  beat_col_c;
  logic [IDX_W-1:0]  beat_addr_c;
  logic              beat_eol_c;
  logic              beat_last_c;

  // Raster position of the current beat; an s_sof beat always lands at the frame origin.
  always_comb begin
    beat_c      = s.s_valid & s.s_ready;
    we_c        = beat_c & ((state == CAPTURE) | ((state == IDLE) & s.s_sof));
    beat_row_c  = s.s_sof ? '0 : row;
    beat_col_c  = s.s_sof ? '0 : col;
    beat_addr_c = s.s_sof ? '0 : wr_addr;
    beat_eol_c  = (beat_col_c == COL_W'(COLS - 1));
    beat_last_c = beat_eol_c & (beat_row_c == ROW_W'(ROWS - 1));
  end

  // Capture FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      s.s_ready  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err_geom   <= 1'b0;
      row        <= '0;
      col        <= '0;
      wr_addr    <= '0;
    end else begin
      frame_done <= 1'b0;
      if (frame_ack) err_geom <= 1'b0;
      case (state)
        IDLE, CAPTURE: begin
          s.s_ready <= 1'b1;
          busy      <= (state == CAPTURE);
          if (we_c) begin
            // A fresh geometry error wins over a simultaneous frame_ack.
            if ((s.s_eol != beat_eol_c) || ((state == CAPTURE) && s.s_sof)) err_geom <= 1'b1;
            wr_addr <= beat_addr_c + IDX_W'(1);
            if (beat_eol_c) begin
              col <= '0;
              row <= beat_row_c + ROW_W'(1);
            end else begin
              col <= beat_col_c + COL_W'(1);
              row <= beat_row_c;
            end
            if (beat_last_c) begin
              state      <= DONE;
              frame_done <= 1'b1;
              s.s_ready  <= 1'b0;
              busy       <= 1'b0;
            end else begin
              state <= CAPTURE;
              busy  <= 1'b1;
            end
          end
        end
        DONE: begin
          s.s_ready <= 1'b0;
          busy      <= 1'b0;
          if (frame_ack) begin
            state     <= IDLE;
            s.s_ready <= 1'b1;
            row       <= '0;
            col       <= '0;
            wr_addr   <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          s.s_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Frame RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (we_c) mem[beat_addr_c] <= s.s_data;
  end

  // Registered read port; out-of-range addresses read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_addr < ADDR_W'(DEPTH)) begin
      rd_data <= mem[rd_addr[IDX_W-1:0]];
    end else begin
      rd_data <= '0;
    end
  end

`ifdef CAPTURE_CHECKSUM_EN
  // Wrapping sum of pixels written in the current frame, restarted by every s_sof beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= 16'h0000;
    end else if (we_c) begin
      checksum <= s.s_sof ? 16'(s.s_data) : checksum + 16'(s.s_data);
    end
  end
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_frame_capture_sink.sv
// Directed scoreboard bench for frame_capture_sink on a 4x5 frame.
module tb_frame_capture_sink;

  localparam int unsigned ROWS   = 4;
  localparam int unsigned COLS   = 5;
  localparam int unsigned NPIX   = ROWS * COLS;
  localparam int unsigned PIX_W  = 8;
  localparam int unsigned ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              frame_ack;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;
  logic              frame_done;
  logic              busy;
  logic              err_geom;
  logic [15:0]       checksum;

  frame_capture_sink_if #(.PIX_W(PIX_W)) bus ();

  frame_capture_sink #(.ROWS(ROWS), .COLS(COLS), .PIX_W(PIX_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s          (bus),
    .frame_ack  (frame_ack),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .frame_done (frame_done),
    .busy       (busy),
    .err_geom   (err_geom),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  int          pass_cnt = 0;
  int          total    = 0;
  int          done_cnt = 0;
  logic [7:0]  exp_mem [NPIX];
  int          m_addr   = 0;
  logic [15:0] m_sum    = 16'h0;
  logic [31:0] rd_q [$];

  always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_csum(input logic [15:0] s);
`ifdef CAPTURE_CHECKSUM_EN
    return s;
`else
    return 16'h0000 & s;
`endif
  endfunction

  // Drive one beat and wait for its transfer; wr says whether the model expects a RAM write.
  task automatic send_beat(input logic [7:0] d, input logic sof, input logic eol,
                           input bit gap, input bit wr);
    int guard;
    if (gap) begin
      bus.s_valid = 1'b0;
      repeat ($urandom_range(0, 2)) step();
    end
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_sof   = sof;
    bus.s_eol   = eol;
    guard = 0;
    while (bus.s_ready !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    chk("ready_wait", 32'(bus.s_ready), 32'd1);
    step();
    if (wr) begin
      if (sof) begin
        m_addr = 0;
        m_sum  = 16'(d);
      end else begin
        m_sum = m_sum + 16'(d);
      end
      exp_mem[m_addr] = d;
      m_addr++;
    end
  endtask

  task automatic send_frame(input int base, input bit gap, input int eol_err_idx, input bit all_ff);
    for (int i = 0; i < int'(NPIX); i++) begin
      send_beat(all_ff ? 8'hFF : 8'(base + i), (i == 0),
                ((i % COLS) == COLS - 1) || (i == eol_err_idx), gap, 1'b1);
    end
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    bus.s_eol   = 1'b0;
  endtask

  // Read via scoreboard: expectation pushed with the address, popped when rd_data is due.
  task automatic read_check(input int a);
    logic [31:0] e;
    rd_addr = 16'(a);
    rd_q.push_back((a < int'(NPIX)) ? 32'(exp_mem[a]) : 32'd0);
    step();
    e = rd_q.pop_front();
    chk($sformatf("rd_data[%0d]", a), 32'(rd_data), e);
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
  endtask

  task automatic check_done(input string tag, input logic err_exp, input int done_before);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd1);
    chk({tag, "_ready_low"}, 32'(bus.s_ready), 32'd0);
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    chk({tag, "_err_geom"}, 32'(err_geom), 32'(err_exp));
    chk({tag, "_checksum"}, 32'(checksum), 32'(exp_csum(m_sum)));
    step();
    chk({tag, "_done_pulse_end"}, 32'(frame_done), 32'd0);
    chk({tag, "_done_count"}, 32'(done_cnt - done_before), 32'd1);
  endtask

  initial begin
    int d0;
    rst_n       = 1'b0;
    frame_ack   = 1'b0;
    rd_addr     = '0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_sof   = 1'b0;
    bus.s_eol   = 1'b0;
    repeat (3) step();
    chk("rst_ready", 32'(bus.s_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_err", 32'(err_geom), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_checksum", 32'(checksum), 32'd0);
    rst_n = 1'b1;
    step();
    step();
    chk("idle_ready", 32'(bus.s_ready), 32'd1);

    // 1: clean frame, continuous valid
    d0 = done_cnt;
    send_frame(0, 1'b0, -1, 1'b0);
    check_done("t1", 1'b0, d0);
    read_check(7);
    read_check(0);
    read_check(19);
    read_check(20);
    read_check(1000);
    ack();
    chk("t1_ack_ready", 32'(bus.s_ready), 32'd1);

    // 2: non-sof beats in IDLE are dropped, then a frame with random valid gaps
    send_beat(8'hEE, 1'b0, 1'b0, 1'b0, 1'b0);
    send_beat(8'hEE, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.s_valid = 1'b0;
    chk("t2_idle_drop_busy", 32'(busy), 32'd0);
    read_check(0);
    d0 = done_cnt;
    send_frame(100, 1'b1, -1, 1'b0);
    check_done("t2", 1'b0, d0);
    for (int a = 0; a < int'(NPIX); a++) read_check(a);
    ack();

    // 3: early s_eol at row 1 col 3
    d0 = done_cnt;
    send_frame(50, 1'b0, 8, 1'b0);
    check_done("t3", 1'b1, d0);
    chk("t3_err_sticky", 32'(err_geom), 32'd1);
    read_check(8);
    ack();
    chk("t3_err_cleared", 32'(err_geom), 32'd0);

    // 4: s_sof re-asserted mid-frame restarts capture
    d0 = done_cnt;
    for (int i = 0; i < 9; i++) send_beat(8'(200 + i), (i == 0), ((i % 5) == 4), 1'b0, 1'b1);
    chk("t4_busy_mid", 32'(busy), 32'd1);
    chk("t4_err_before", 32'(err_geom), 32'd0);
    send_beat(8'd30, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t4_err_restart", 32'(err_geom), 32'd1);
    chk("t4_no_early_done", 32'(done_cnt - d0), 32'd0);
    for (int i = 1; i < int'(NPIX); i++) send_beat(8'(30 + i), 1'b0, ((i % 5) == 4), 1'b0, 1'b1);
    bus.s_valid = 1'b0;
    check_done("t4", 1'b1, d0);
    read_check(8);
    read_check(9);
    ack();

    // 5: reset mid-frame
    d0 = done_cnt;
    for (int i = 0; i < 10; i++) send_beat(8'(70 + i), (i == 0), ((i % 5) == 4), 1'b0, 1'b1);
    bus.s_valid = 1'b0;
    read_check(3);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ready", 32'(bus.s_ready), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_err", 32'(err_geom), 32'd0);
    chk("t5_rst_rd_data", 32'(rd_data), 32'd0);
    chk("t5_rst_checksum", 32'(checksum), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
    send_frame(150, 1'b0, -1, 1'b0);
    check_done("t5", 1'b0, d0);
    read_check(0);
    read_check(12);
    ack();

    // 6: all-0xFF frame drives the checksum to 5100 when enabled
    d0 = done_cnt;
    send_frame(0, 1'b0, -1, 1'b1);
`ifdef CAPTURE_CHECKSUM_EN
    chk("t6_checksum_const", 32'(checksum), 32'd5100);
`else
    chk("t6_checksum_const", 32'(checksum), 32'd0);
`endif
    check_done("t6", 1'b0, d0);
    read_check(5);
    ack();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
